// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- memory stage sitting directly behind execute.
//
// Non-memory instructions pass straight through to a one-cycle write-back
// beat. Loads and stores run one access at a time on a request/ready data
// bus; `busy` holds upstream while that access is in flight. An access that
// sees no `mem_ready` for TIMEOUT cycles is aborted with `bus_error`.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the bus and return a
//               bus_error write-back beat on the next edge.
//   undefined : low offset bits are ignored for alignment; no alignment error.
//
// Parameters
//   TIMEOUT : cycles mem_req may stay high without mem_ready (>= 1)
//   ADDR_W  : bus address width
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   in_valid                : execute output valid
//   is_load, is_store       : memory operation flags (store wins if both)
//   func3                   : access size / sign
//   result                  : ALU result or effective address
//   store_data              : rs2 value for stores
//   dest_i                  : destination register
//   busy                    : stage cannot accept this cycle
//   mem_req/we/addr/wdata/wstrb, mem_ready, mem_rdata : data bus
//   wb_valid, wb_dest, wb_data : one-cycle write-back beat
//   bus_error               : one-cycle pulse on timeout (or misalign trap)
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        func3,
  input  logic [31:0]       result,
  input  logic [31:0]       store_data,
  input  logic [4:0]        dest_i,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_dest,
  output logic [31:0]       wb_data,
  output logic              bus_error
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt_p1;
  logic [1:0]       off_p1;
  logic [2:0]       func3_p1;
  logic [4:0]       dest_p1;
  logic             accept;
  logic             is_mem;
  logic             trap;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store value across every lane it could occupy.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sdata);
    case (f3[1:0])
      2'b00:   return {4{sdata[7:0]}};
      2'b01:   return {2{sdata[15:0]}};
      default: return sdata;
    endcase
  endfunction

  // Pull the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || (f3[1] && (off != 2'b00));
  endfunction

  assign trap = misaligned(func3, result[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign busy   = (state == ACCESS);
  assign accept = in_valid && !busy;
  assign is_mem = is_load || is_store;

  // Accept/issue stage (IDLE) and bus completion stage (ACCESS)
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt_p1    <= '0;
      off_p1    <= '0;
      func3_p1  <= '0;
      dest_p1   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_valid  <= 1'b0;
      wb_dest   <= '0;
      wb_data   <= '0;
      bus_error <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_dest  <= dest_i;
              wb_data  <= result;
            end else if (trap) begin
              wb_valid  <= 1'b1;
              bus_error <= 1'b1;
              wb_dest   <= '0;
              wb_data   <= '0;
            end else begin
              state     <= ACCESS;
              cnt_p1    <= '0;
              off_p1    <= result[1:0];
              func3_p1  <= func3;
              dest_p1   <= dest_i;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= ADDR_W'({result[31:2], 2'b00});
              mem_wdata <= is_store ? lane_wdata(func3, store_data) : 32'h0;
              mem_wstrb <= is_store ? lane_strb(func3, result[1:0]) : 4'b0000;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            wb_valid  <= 1'b1;
            if (mem_we) begin
              wb_dest <= '0;
              wb_data <= '0;
            end else begin
              wb_dest <= dest_p1;
              wb_data <= load_extract(func3_p1, off_p1, mem_rdata);
            end
          end else if (cnt_p1 == CNT_LAST) begin
            // No ready within TIMEOUT cycles of request: abandon the access.
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            wb_valid  <= 1'b1;
            bus_error <= 1'b1;
            wb_dest   <= '0;
            wb_data   <= '0;
          end else begin
            cnt_p1 <= cnt_p1 + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
